// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM state encoding and grant codes.
// Used by mem_arbiter and mem_arb_pick; the MEM_ARB_RR_EN build option is documented in mem_arb_pick.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_t;

    // Encoding of the last-grant bit used by the round-robin option.
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the pipeline fetch/data ports, the arbiter and the unified memory.
// slave = arbiter view, master = environment (pipeline + memory) view.
interface mem_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_cancel;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;
    logic              i_stall;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_stall;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, i_cancel,
        input  d_req, d_wr, d_addr, d_wdata,
        input  mem_valid, mem_rdata,
        output i_rdata, i_done, i_stall,
        output d_rdata, d_done, d_stall,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, i_cancel,
        output d_req, d_wr, d_addr, d_wdata,
        output mem_valid, mem_rdata,
        input  i_rdata, i_done, i_stall,
        input  d_rdata, d_done, d_stall,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant select for the arbiter's IDLE state.
// MEM_ARB_RR_EN defined: alternate ports on a tie using the last-grant bit; otherwise data always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_fetch_req,
    input  logic i_data_req,
    input  logic i_fetch_cancel,
    input  logic i_last_gnt,
    output gnt_t o_gnt
);

    logic w_fetch_ok;

    // A cancelled fetch is not eligible this cycle; the new PC arrives next cycle.
    assign w_fetch_ok = i_fetch_req & ~i_fetch_cancel;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        o_gnt = GNT_NONE;
        if (i_data_req && w_fetch_ok) begin
            o_gnt = (i_last_gnt == LAST_D) ? GNT_I : GNT_D;
        end else if (i_data_req) begin
            o_gnt = GNT_D;
        end else if (w_fetch_ok) begin
            o_gnt = GNT_I;
        end
    end
`else
    logic w_unused_last_gnt;
    assign w_unused_last_gnt = i_last_gnt;

    always_comb begin
        o_gnt = GNT_NONE;
        if (i_data_req) begin
            o_gnt = GNT_D;
        end else if (w_fetch_ok) begin
            o_gnt = GNT_I;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported multi-cycle memory between the fetch and data ports, one access at a time.
// Build option MEM_ARB_RR_EN: round-robin on simultaneous requests (adds a last-grant register).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic      clk,
    input logic      rst,
    mem_arb_if.slave bus
);

    state_t            r_state,     w_state_nxt;
    logic              r_mem_en,    w_mem_en_nxt;
    logic              r_mem_wr,    w_mem_wr_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_i_rdata,   w_i_rdata_nxt;
    logic [DATA_W-1:0] r_d_rdata,   w_d_rdata_nxt;
    logic              r_i_done,    w_i_done_nxt;
    logic              r_d_done,    w_d_done_nxt;
    logic              r_cancel,    w_cancel_nxt;

    gnt_t w_gnt;
    logic w_last_gnt;
    logic w_cancelled;

    mem_arb_pick u_pick (
        .i_fetch_req    (bus.i_req),
        .i_data_req     (bus.d_req),
        .i_fetch_cancel (bus.i_cancel),
        .i_last_gnt     (w_last_gnt),
        .o_gnt          (w_gnt)
    );

`ifdef MEM_ARB_RR_EN
    logic r_last_gnt, w_last_gnt_nxt;

    assign w_last_gnt = r_last_gnt;

    always_comb begin
        w_last_gnt_nxt = r_last_gnt;
        if (r_state == IDLE) begin
            if (w_gnt == GNT_D) begin
                w_last_gnt_nxt = LAST_D;
            end else if (w_gnt == GNT_I) begin
                w_last_gnt_nxt = LAST_I;
            end
        end
    end

    // Reset to "fetch" so the very first tie goes to the data port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= LAST_I;
        end else begin
            r_last_gnt <= w_last_gnt_nxt;
        end
    end
`else
    assign w_last_gnt = LAST_I;
`endif

    // A cancel arriving on the same cycle as mem_valid still discards the fetch.
    assign w_cancelled = r_cancel | bus.i_cancel;

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_en_nxt    = r_mem_en;
        w_mem_wr_nxt    = r_mem_wr;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_i_rdata_nxt   = r_i_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_i_done_nxt    = 1'b0;
        w_d_done_nxt    = 1'b0;
        w_cancel_nxt    = r_cancel;

        case (r_state)
            IDLE: begin
                case (w_gnt)
                    GNT_D: begin
                        w_mem_en_nxt    = 1'b1;
                        w_mem_wr_nxt    = bus.d_wr;
                        w_mem_addr_nxt  = bus.d_addr;
                        w_mem_wdata_nxt = bus.d_wdata;
                        w_state_nxt     = BUSY_D;
                    end
                    GNT_I: begin
                        w_mem_en_nxt   = 1'b1;
                        w_mem_wr_nxt   = 1'b0;
                        w_mem_addr_nxt = bus.i_addr;
                        w_state_nxt    = BUSY_I;
                    end
                    default: begin
                    end
                endcase
            end

            BUSY_I: begin
                w_cancel_nxt = w_cancelled;
                if (bus.mem_valid) begin
                    w_mem_en_nxt = 1'b0;
                    w_state_nxt  = RESP;
                    if (!w_cancelled) begin
                        w_i_rdata_nxt = bus.mem_rdata;
                        w_i_done_nxt  = 1'b1;
                    end
                end
            end

            BUSY_D: begin
                if (bus.mem_valid) begin
                    w_mem_en_nxt  = 1'b0;
                    w_d_rdata_nxt = bus.mem_wr ? r_d_rdata : bus.mem_rdata;
                    w_d_done_nxt  = 1'b1;
                    w_state_nxt   = RESP;
                end
            end

            // Done pulse is visible here; nothing issues until back in IDLE.
            RESP: begin
                w_cancel_nxt = 1'b0;
                w_state_nxt  = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_cancel    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_i_rdata   <= w_i_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_i_done    <= w_i_done_nxt;
            r_d_done    <= w_d_done_nxt;
            r_cancel    <= w_cancel_nxt;
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.i_done    = r_i_done;
    assign bus.d_done    = r_d_done;
    assign bus.i_stall   = bus.i_req & ~r_i_done;
    assign bus.d_stall   = bus.d_req & ~r_d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// memory-level reference model. Expected grant order follows MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_mem     [0:65535];
    logic [15:0] phys_mem    [0:65535];
    bit          phys_written[0:65535];

    int mem_lat     = 3;
    bit mem_mute    = 1'b0;
    bit force_valid = 1'b0;
    int resp_cnt    = 0;

    logic [15:0] exp_i_rdata;
    logic [15:0] exp_d_rdata;
    bit          model_last_d;

    function automatic logic [15:0] init_pat(input logic [15:0] a);
        if (a == 16'h0010) return 16'hA123;
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Memory model: answers mem_en after mem_lat cycles with a one-cycle mem_valid.
    always @(negedge clk) begin
        bus.mem_valid <= 1'b0;
        if (force_valid) begin
            bus.mem_valid <= 1'b1;
            bus.mem_rdata <= 16'hFFFF;
        end else if (!bus.mem_en || mem_mute) begin
            resp_cnt <= 0;
        end else if (resp_cnt + 1 >= mem_lat) begin
            bus.mem_valid <= 1'b1;
            bus.mem_rdata <= phys_written[bus.mem_addr] ? phys_mem[bus.mem_addr] : init_pat(bus.mem_addr);
            if (bus.mem_wr) begin
                phys_mem[bus.mem_addr]     <= bus.mem_wdata;
                phys_written[bus.mem_addr] <= 1'b1;
            end
            resp_cnt <= 0;
        end else begin
            resp_cnt <= resp_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req    = 1'b0;
        bus.i_addr   = '0;
        bus.i_cancel = 1'b0;
        bus.d_req    = 1'b0;
        bus.d_wr     = 1'b0;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_i_rdata  = 16'h0000;
        exp_d_rdata  = 16'h0000;
        model_last_d = 1'b0;
    endtask

    task automatic wait_done(input bit port_d, output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            cyc++;
            if (port_d ? bus.d_done : bus.i_done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        checks++;
        if ({bus.mem_en, bus.mem_wr, bus.i_done, bus.d_done, bus.i_stall, bus.d_stall} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {bus.mem_en, bus.mem_wr, bus.i_done, bus.d_done, bus.i_stall, bus.d_stall});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mem_bus: got %h expected 0", {bus.mem_addr, bus.mem_wdata});
        end
        checks++;
        if ({bus.i_rdata, bus.d_rdata} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: got %h expected 0", {bus.i_rdata, bus.d_rdata});
        end
        tick();
        checks++;
        if (bus.mem_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_no_issue: mem_en got %b expected 0", bus.mem_en);
        end
    endtask

    task automatic test_fetch();
        int cyc;
        bit seen;
        mem_lat     = 4;
        bus.i_addr  = 16'h0010;
        bus.i_req   = 1'b1;
        tick();
        checks++;
        if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.i_stall} !== {1'b1, 1'b0, 16'h0010, 1'b1}) begin
            errors++;
            $display("[TB] FAIL fetch_grant: en/wr/addr/stall got %b/%b/%h/%b expected 1/0/0010/1",
                     bus.mem_en, bus.mem_wr, bus.mem_addr, bus.i_stall);
        end
        wait_done(1'b0, cyc, seen);
        checks++;
        if (!seen || cyc != 4) begin
            errors++;
            $display("[TB] FAIL fetch_latency: done seen=%0b after %0d cycles expected 4", seen, cyc);
        end
        exp_i_rdata = ref_mem[16'h0010];
        checks++;
        if ({bus.i_rdata, bus.i_stall, bus.mem_en} !== {exp_i_rdata, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL fetch_data: rdata/stall/en got %h/%b/%b expected %h/0/0",
                     bus.i_rdata, bus.i_stall, bus.mem_en, exp_i_rdata);
        end
        bus.i_req = 1'b0;
        tick();
        checks++;
        if (bus.i_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fetch_done_pulse: i_done got %b expected 0", bus.i_done);
        end
        tick();
    endtask

    task automatic test_priority();
        int cyc;
        bit seen;
        mem_lat     = 2;
        bus.i_addr  = 16'h0020;
        bus.d_addr  = 16'h0200;
        bus.d_wr    = 1'b0;
        bus.d_wdata = 16'h0000;
        bus.i_req   = 1'b1;
        bus.d_req   = 1'b1;
        tick();
        checks++;
        if ({bus.mem_en, bus.mem_addr, bus.i_stall, bus.d_stall} !== {1'b1, 16'h0200, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL prio_data_first: en/addr/istall/dstall got %b/%h/%b/%b expected 1/0200/1/1",
                     bus.mem_en, bus.mem_addr, bus.i_stall, bus.d_stall);
        end
        wait_done(1'b1, cyc, seen);
        exp_d_rdata  = ref_mem[16'h0200];
        model_last_d = 1'b1;
        checks++;
        if (!seen || cyc != 2 || bus.d_rdata !== exp_d_rdata || bus.i_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_data_done: seen=%0b cyc=%0d rdata=%h i_done=%b expected 1/2/%h/0",
                     seen, cyc, bus.d_rdata, bus.i_done, exp_d_rdata);
        end
        bus.d_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.mem_en, bus.mem_addr, bus.mem_wr} !== {1'b1, 16'h0020, 1'b0}) begin
            errors++;
            $display("[TB] FAIL prio_fetch_next: en/addr/wr got %b/%h/%b expected 1/0020/0",
                     bus.mem_en, bus.mem_addr, bus.mem_wr);
        end
        wait_done(1'b0, cyc, seen);
        exp_i_rdata = ref_mem[16'h0020];
        checks++;
        if (!seen || bus.i_rdata !== exp_i_rdata || bus.d_rdata !== exp_d_rdata) begin
            errors++;
            $display("[TB] FAIL prio_fetch_done: seen=%0b irdata=%h drdata=%h expected %h/%h",
                     seen, bus.i_rdata, bus.d_rdata, exp_i_rdata, exp_d_rdata);
        end
        bus.i_req = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int cyc;
        bit seen;
        seen        = 1'b0;
        mem_lat     = 3;
        bus.d_addr  = 16'h0300;
        bus.d_wdata = 16'hBEEF;
        bus.d_wr    = 1'b1;
        bus.d_req   = 1'b1;
        tick();
        for (int k = 0; k < 100; k++) begin
            if (bus.d_done) begin
                seen = 1'b1;
                break;
            end
            checks++;
            if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 16'h0300, 16'hBEEF}) begin
                errors++;
                $display("[TB] FAIL write_stable: en/wr/addr/wdata got %b/%b/%h/%h expected 1/1/0300/BEEF",
                         bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
            end
            tick();
        end
        ref_mem[16'h0300] = 16'hBEEF;
        checks++;
        if (!seen || bus.d_rdata !== exp_d_rdata) begin
            errors++;
            $display("[TB] FAIL write_done: seen=%0b d_rdata=%h expected 1/%h", seen, bus.d_rdata, exp_d_rdata);
        end
        bus.d_req = 1'b0;
        bus.d_wr  = 1'b0;
        tick();
        bus.d_req = 1'b1;
        wait_done(1'b1, cyc, seen);
        exp_d_rdata = ref_mem[16'h0300];
        checks++;
        if (!seen || bus.d_rdata !== exp_d_rdata) begin
            errors++;
            $display("[TB] FAIL write_readback: seen=%0b d_rdata=%h expected %h", seen, bus.d_rdata, exp_d_rdata);
        end
        bus.d_req = 1'b0;
        tick();
    endtask

    task automatic test_cancel();
        int  cyc;
        int  en_cycles;
        bit  seen;
        bit  dropped;
        bit  bad;
        mem_lat    = 5;
        bus.i_addr = 16'h0030;
        bus.i_req  = 1'b1;
        tick();
        en_cycles = bus.mem_en ? 1 : 0;
        bus.i_cancel = 1'b1;
        tick();
        bus.i_cancel = 1'b0;
        bus.i_addr   = 16'h0040;
        dropped = 1'b0;
        bad     = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (!bus.mem_en) begin
                dropped = 1'b1;
                break;
            end
            en_cycles++;
            if (bus.i_done || bus.mem_addr !== 16'h0030) bad = 1'b1;
            tick();
        end
        checks++;
        if (!dropped || bad || en_cycles != 5) begin
            errors++;
            $display("[TB] FAIL cancel_hold: dropped=%0b bad=%0b en_cycles=%0d expected 1/0/5", dropped, bad, en_cycles);
        end
        checks++;
        if (bus.i_done !== 1'b0 || bus.i_rdata !== exp_i_rdata) begin
            errors++;
            $display("[TB] FAIL cancel_no_done: i_done=%b i_rdata=%h expected 0/%h", bus.i_done, bus.i_rdata, exp_i_rdata);
        end
        tick();
        tick();
        checks++;
        if ({bus.mem_en, bus.mem_addr} !== {1'b1, 16'h0040}) begin
            errors++;
            $display("[TB] FAIL cancel_new_pc: en/addr got %b/%h expected 1/0040", bus.mem_en, bus.mem_addr);
        end
        wait_done(1'b0, cyc, seen);
        exp_i_rdata = ref_mem[16'h0040];
        checks++;
        if (!seen || bus.i_rdata !== exp_i_rdata) begin
            errors++;
            $display("[TB] FAIL cancel_refetch: seen=%0b i_rdata=%h expected %h", seen, bus.i_rdata, exp_i_rdata);
        end
        bus.i_req = 1'b0;
        tick();

        bus.i_addr   = 16'h0050;
        bus.i_req    = 1'b1;
        bus.i_cancel = 1'b1;
        mem_lat      = 1;
        tick();
        checks++;
        if (bus.mem_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cancel_idle_suppress: mem_en got %b expected 0", bus.mem_en);
        end
        bus.i_cancel = 1'b0;
        tick();
        checks++;
        if ({bus.mem_en, bus.mem_addr} !== {1'b1, 16'h0050}) begin
            errors++;
            $display("[TB] FAIL cancel_idle_issue: en/addr got %b/%h expected 1/0050", bus.mem_en, bus.mem_addr);
        end
        wait_done(1'b0, cyc, seen);
        exp_i_rdata = ref_mem[16'h0050];
        bus.i_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit seen;
        mem_mute    = 1'b1;
        bus.d_addr  = 16'h0500;
        bus.d_wdata = 16'h1234;
        bus.d_wr    = 1'b1;
        bus.d_req   = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.d_req = 1'b0;
        bus.d_wr  = 1'b0;
        checks++;
        if ({bus.mem_en, bus.mem_wr, bus.d_done, bus.i_done, bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata}
            !== {4'b0, 64'h0}) begin
            errors++;
            $display("[TB] FAIL reset_mid_access: en/wr=%b/%b addr=%h wdata=%h rdata=%h/%h expected all 0",
                     bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata);
        end
        exp_i_rdata  = 16'h0000;
        exp_d_rdata  = 16'h0000;
        model_last_d = 1'b0;
        force_valid  = 1'b1;
        @(negedge clk);
        #1;
        force_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.mem_en, bus.d_done, bus.i_done, bus.i_rdata, bus.d_rdata} !== {3'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL late_valid_ignored: en/ddone/idone=%b/%b/%b rdata=%h/%h expected 0",
                     bus.mem_en, bus.d_done, bus.i_done, bus.i_rdata, bus.d_rdata);
        end
        mem_mute  = 1'b0;
        mem_lat   = 2;
        bus.d_req = 1'b1;
        wait_done(1'b1, cyc, seen);
        exp_d_rdata  = ref_mem[16'h0500];
        model_last_d = 1'b1;
        checks++;
        if (!seen || bus.d_rdata !== exp_d_rdata) begin
            errors++;
            $display("[TB] FAIL reset_no_write: seen=%0b d_rdata=%h expected %h", seen, bus.d_rdata, exp_d_rdata);
        end
        bus.d_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bit got;
        bit exp_d;
        idle_inputs();
        do_reset();
        mem_lat    = 1;
        bus.i_addr = 16'h0700;
        bus.d_addr = 16'h0600;
        bus.i_req  = 1'b1;
        bus.d_req  = 1'b1;
        for (int n = 0; n < 4; n++) begin
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (bus.mem_en) begin
                    got = 1'b1;
                    break;
                end
            end
`ifdef MEM_ARB_RR_EN
            exp_d = ~model_last_d;
`else
            exp_d = 1'b1;
`endif
            model_last_d = exp_d;
            checks++;
            if (!got || ((bus.mem_addr == 16'h0600) !== exp_d)) begin
                errors++;
                $display("[TB] FAIL grant_order[%0d]: got=%0b data_granted=%b expected %b",
                         n, got, (bus.mem_addr == 16'h0600), exp_d);
            end
            for (int k = 0; k < 20; k++) begin
                tick();
                if (!bus.mem_en) break;
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_random();
        idle_inputs();
        do_reset();
        for (int t = 0; t < 40; t++) begin
            int          pat;
            int          lat;
            int          cyc;
            int          ndone;
            int          first;
            bit          exp_first_d;
            logic [15:0] ia;
            logic [15:0] da;
            logic [15:0] wd;
            bit          dw;
            pat   = $urandom_range(0, 2);
            lat   = $urandom_range(1, 6);
            ia    = 16'h1000 | 16'($urandom_range(0, 255));
            da    = 16'h2000 | 16'($urandom_range(0, 63));
            wd    = 16'($urandom);
            dw    = 1'($urandom_range(0, 1));
            mem_lat = lat;
            if (pat == 0) begin
                exp_first_d = 1'b0;
            end else if (pat == 1) begin
                exp_first_d = 1'b1;
            end else begin
`ifdef MEM_ARB_RR_EN
                exp_first_d = ~model_last_d;
`else
                exp_first_d = 1'b1;
`endif
            end
            bus.i_addr  = ia;
            bus.d_addr  = da;
            bus.d_wr    = dw;
            bus.d_wdata = wd;
            bus.i_req   = (pat != 1);
            bus.d_req   = (pat != 0);
            ndone = 0;
            first = -1;
            cyc   = 0;
            for (int k = 0; k < 200 && ndone < ((pat == 2) ? 2 : 1); k++) begin
                tick();
                cyc++;
                if (bus.d_done) begin
                    if (first < 0) first = 1;
                    if (!dw) exp_d_rdata = ref_mem[da];
                    else ref_mem[da] = wd;
                    checks++;
                    if (bus.d_rdata !== exp_d_rdata) begin
                        errors++;
                        $display("[TB] FAIL rand_d_rdata[%0d]: got %h expected %h (addr %h wr %0b)",
                                 t, bus.d_rdata, exp_d_rdata, da, dw);
                    end
                    model_last_d = 1'b1;
                    bus.d_req = 1'b0;
                    ndone++;
                end
                if (bus.i_done) begin
                    if (first < 0) first = 0;
                    exp_i_rdata = ref_mem[ia];
                    checks++;
                    if (bus.i_rdata !== exp_i_rdata) begin
                        errors++;
                        $display("[TB] FAIL rand_i_rdata[%0d]: got %h expected %h (addr %h)",
                                 t, bus.i_rdata, exp_i_rdata, ia);
                    end
                    model_last_d = 1'b0;
                    bus.i_req = 1'b0;
                    ndone++;
                end
                if (first >= 0 && ndone == 1 && pat != 2) begin
                    checks++;
                    if (cyc != lat + 1) begin
                        errors++;
                        $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", t, cyc, lat + 1);
                    end
                end
            end
            checks++;
            if (ndone != ((pat == 2) ? 2 : 1) || first != int'(exp_first_d)) begin
                errors++;
                $display("[TB] FAIL rand_order[%0d]: dones=%0d first=%0d expected first %0d",
                         t, ndone, first, exp_first_d);
            end
            idle_inputs();
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        for (int a = 0; a < 65536; a++) begin
            ref_mem[a] = init_pat(16'(a));
        end
        test_reset();
        test_fetch();
        test_priority();
        test_write();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
